// File: rtl/dot_operand_feeder_pkg.sv
// Shared constants and state encoding for the dot-product feeder and its compute block.
package dot_operand_feeder_pkg;

  localparam int DEPTH   = 8;
  localparam int WIDTH   = 8;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 4;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int HOLD_W = $clog2(DEPTH + 2);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_STREAM,
    S_WAIT
  } state_t;

endpackage

// File: rtl/dot_operand_feeder_operand_bank.sv
// DEPTH x WIDTH operand register file: synchronous write and clear, asynchronous read.
module operand_bank
  import dot_operand_feeder_pkg::*;
(
  input  logic              CLK,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is cleared on reset only because stale operands must never reach the
  // compute block; storage without that need is normally left unreset.
  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dot_operand_feeder.sv
// Loads operand vectors A/B, kicks the compute block, streams element pairs and captures the result.
module dot_operand_feeder
  import dot_operand_feeder_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic              WSEL,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic              GO,
  input  logic              DONE_IN,
  input  logic [RES_W-1:0]  RESULT_IN,
  output logic              START_OUT,
  output logic [WIDTH-1:0]  A_OUT,
  output logic [WIDTH-1:0]  B_OUT,
  output logic              BUSY,
  output logic [RES_W-1:0]  DOT_RESULT,
  output logic              RESULT_VALID,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DEPTH + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, rd_idx;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               start_q, start_d, busy_q, busy_d;
  logic               valid_q, valid_d, err_q, err_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, a_rdata, b_rdata;
  logic [RES_W-1:0]   res_q, res_d;

  // Writes are frozen for the whole run so the streamed vectors stay coherent.
  logic wr_ok;
  assign wr_ok = WE && !busy_q;

  operand_bank u_bank_a (
    .CLK(CLK), .clr(RST), .we(wr_ok && !WSEL), .waddr(WADDR), .wdata(WDATA),
    .raddr(rd_idx), .rdata(a_rdata)
  );

  operand_bank u_bank_b (
    .CLK(CLK), .clr(RST), .we(wr_ok && WSEL), .waddr(WADDR), .wdata(WDATA),
    .raddr(rd_idx), .rdata(b_rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    hold_d  = (hold_q != '0) ? hold_q - 1'b1 : '0;
    start_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    res_d   = res_q;
    valid_d = valid_q;
    err_d   = err_q;
    rd_idx  = '0;

    case (state_q)
      S_IDLE: begin
        if (GO && hold_q == '0 && !busy_q) begin
          state_d = S_KICK;
          start_d = 1'b1;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_KICK: begin
        state_d = S_STREAM;
        idx_d   = '0;
        a_d     = a_rdata;
        b_d     = b_rdata;
      end
      S_STREAM: begin
        // Pre-fetch the next pair so the registered outputs line up with the stream index.
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
          rd_idx = idx_q + 1'b1;
          a_d    = a_rdata;
          b_d    = b_rdata;
        end
      end
      S_WAIT: begin
        if (DONE_IN) begin
          res_d   = RESULT_IN;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q + 1'b1 == WAIT_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (hold_d != '0) || (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      hold_q  <= HOLD_LOAD;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign START_OUT    = start_q;
  assign A_OUT        = a_q;
  assign B_OUT        = b_q;
  assign BUSY         = busy_q;
  assign DOT_RESULT   = res_q;
  assign RESULT_VALID = valid_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_dot_operand_feeder.sv
// Directed bench for dot_operand_feeder with a small behavioural compute block.
module tb_dot_operand_feeder;

  logic        CLK, RST, WE, WSEL, GO, DONE_IN;
  logic [2:0]  WADDR;
  logic [7:0]  WDATA, A_OUT, B_OUT;
  logic [15:0] RESULT_IN, DOT_RESULT;
  logic        START_OUT, BUSY, RESULT_VALID, ERR;

  int n_checks = 0;
  int n_fail   = 0;

  dot_operand_feeder dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WSEL(WSEL), .WADDR(WADDR), .WDATA(WDATA),
    .GO(GO), .DONE_IN(DONE_IN), .RESULT_IN(RESULT_IN), .START_OUT(START_OUT),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .BUSY(BUSY), .DOT_RESULT(DOT_RESULT),
    .RESULT_VALID(RESULT_VALID), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compute block model: no reset, accumulates 8 pairs after START, raises DONE one cycle later.
  logic        model_en = 1'b1;
  logic        m_act    = 1'b0;
  int          m_cnt    = 0;
  int          starts   = 0;
  logic [15:0] m_acc    = '0;

  always @(negedge CLK) begin
    if (START_OUT === 1'b1) begin
      m_act = 1'b1;
      m_cnt = 0;
      m_acc = '0;
      starts++;
    end else if (m_act) begin
      m_cnt++;
      if (m_cnt <= 8) begin
        m_acc = m_acc + 16'(A_OUT) * 16'(B_OUT);
      end else if (m_cnt == 9) begin
        if (model_en) begin
          DONE_IN   = 1'b1;
          RESULT_IN = m_acc;
        end
      end else begin
        DONE_IN = 1'b0;
        m_act   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic wr(input logic sel, input int addr, input logic [7:0] d);
    WE = 1'b1; WSEL = sel; WADDR = 3'(addr); WDATA = d;
    cyc();
    WE = 1'b0;
  endtask

  task automatic go();
    GO = 1'b1;
    cyc();
    GO = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) check({tag, " idle bound"}, BUSY, 0);
  endtask

  initial begin
    int s0;
    RST = 1'b1; WE = 1'b0; WSEL = 1'b0; WADDR = '0; WDATA = '0;
    GO = 1'b0; DONE_IN = 1'b0; RESULT_IN = '0;
    cyc(); cyc();
    check("rst start", START_OUT, 0);
    check("rst a_out", A_OUT, 0);
    check("rst result", DOT_RESULT, 0);
    check("rst valid", RESULT_VALID, 0);
    check("rst err", ERR, 0);
    check("rst busy", BUSY, 1);
    RST = 1'b0;
    wait_idle("holdoff");

    // Run 1: A = 1..8, B = 1, cycle-exact checks.
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, 8'(i + 1));
      wr(1'b1, i, 8'd1);
    end
    go();
    check("c1 start", START_OUT, 1);
    check("c1 busy", BUSY, 1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("stream start", START_OUT, 0);
      check("stream a", A_OUT, k + 1);
      check("stream b", B_OUT, 1);
    end
    cyc();
    check("c10 a_out", A_OUT, 0);
    check("c10 valid", RESULT_VALID, 0);
    cyc();
    check("c11 result", DOT_RESULT, 16'h0024);
    check("c11 valid", RESULT_VALID, 1);
    check("c11 busy", BUSY, 0);
    check("c11 err", ERR, 0);

    // Run 2: all 0xFF, truncated sum.
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, 8'hFF);
      wr(1'b1, i, 8'hFF);
    end
    go();
    wait_idle("run2");
    check("ff result", DOT_RESULT, 16'hF008);
    check("ff valid", RESULT_VALID, 1);
    check("ff err", ERR, 0);

    // Run 3: no DONE, timeout after 4 WAIT cycles.
    model_en = 1'b0;
    go();
    for (int i = 0; i < 12; i++) cyc();
    check("c13 err", ERR, 0);
    check("c13 busy", BUSY, 1);
    cyc();
    check("to err", ERR, 1);
    check("to valid", RESULT_VALID, 0);
    check("to result", DOT_RESULT, 16'hF008);
    check("to busy", BUSY, 0);
    model_en = 1'b1;

    // Run 4: B one-hot at 3, write A[3] and pulse GO while busy.
    for (int i = 0; i < 8; i++) wr(1'b1, i, (i == 3) ? 8'd1 : 8'd0);
    s0 = starts;
    go();
    check("go clears err", ERR, 0);
    cyc(); cyc();
    wr(1'b0, 3, 8'h55);
    go();
    wait_idle("run4");
    check("drop result", DOT_RESULT, 16'h00FF);
    check("drop valid", RESULT_VALID, 1);
    for (int i = 0; i < 3; i++) cyc();
    check("no 2nd start", starts - s0, 1);
    go();
    wait_idle("run4b");
    check("drop rerun", DOT_RESULT, 16'h00FF);

    // Run 5: reset in stream cycle 4, then holdoff.
    go();
    for (int i = 0; i < 5; i++) cyc();
    check("s4 a_out", A_OUT, 8'hFF);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check("mid rst start", START_OUT, 0);
    check("mid rst a", A_OUT, 0);
    check("mid rst b", B_OUT, 0);
    check("mid rst result", DOT_RESULT, 0);
    check("mid rst valid", RESULT_VALID, 0);
    check("mid rst err", ERR, 0);
    check("mid rst busy", BUSY, 1);
    GO = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("holdoff start", START_OUT, 0);
      check("holdoff busy", BUSY, (i < 8) ? 1 : 0);
    end
    cyc();
    GO = 1'b0;
    check("post holdoff start", START_OUT, 1);
    wait_idle("run5");
    check("cleared banks", DOT_RESULT, 0);
    check("run5 valid", RESULT_VALID, 1);

    // Run 6: write B[0] on the same edge GO is accepted.
    wr(1'b0, 0, 8'h03);
    WE = 1'b1; WSEL = 1'b1; WADDR = 3'd0; WDATA = 8'h02;
    go();
    WE = 1'b0;
    wait_idle("run6");
    check("same-edge write", DOT_RESULT, 16'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_operand_feeder.md
Name: dot_operand_feeder

Overview:
Upstream stage of the dot-product compute block. Holds two DEPTH-entry operand vectors A and B, loaded through a simple write port. On GO it issues a one-cycle start pulse, then streams element pairs A[k]/B[k] to the compute block on consecutive cycles. It then waits for the compute block's done flag and captures the 16-bit result for the host.

Parameters:
DEPTH, 8, elements per vector; must equal the compute block's iteration count.
WIDTH, 8, element width in bits.
RES_W, 16, result width in bits.
TIMEOUT, 4, maximum cycles spent in WAIT for DONE_IN before ERR is set.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous, active-high reset.
WE  in  1  write enable for the operand banks.
WSEL  in  1  bank select: 0 selects A, 1 selects B.
WADDR  in  clog2(DEPTH)  element index.
WDATA  in  WIDTH  element value.
GO  in  1  request a run; sampled only in IDLE.
DONE_IN  in  1  done flag from the compute block.
RESULT_IN  in  RES_W  result from the compute block.
START_OUT  out  1  one-cycle start pulse to the compute block.
A_OUT  out  WIDTH  streamed element of A.
B_OUT  out  WIDTH  streamed element of B.
BUSY  out  1  high in any state other than IDLE, and during the post-reset holdoff.
DOT_RESULT  out  RES_W  captured result; holds its value until the next capture.
RESULT_VALID  out  1  high from capture until the next GO is accepted.
ERR  out  1  sticky timeout flag; cleared when the next GO is accepted.

Behaviour:
- All outputs are registered.
- Reset:
  - State goes to IDLE.
  - Both banks are cleared to 0.
  - START_OUT, A_OUT, B_OUT, DOT_RESULT, RESULT_VALID and ERR are all 0.
  - The holdoff counter is loaded with DEPTH+1. This lets a compute block that has no reset finish any run in flight.
  - BUSY=1 and GO is ignored until the holdoff counter reaches 0.
- Writes:
  - Accepted only when BUSY=0.
  - A write on the same edge that GO is accepted takes effect and is visible to that run.
  - Writes while BUSY=1 are silently dropped.
- State machine states: IDLE, KICK, STREAM, WAIT.
- IDLE:
  - When GO=1, holdoff=0 and BUSY=0 at an edge, move to KICK.
  - On that edge, RESULT_VALID and ERR are cleared.
- KICK:
  - START_OUT=1 for exactly this one cycle.
  - Next state is STREAM, with index k=0.
- STREAM:
  - Lasts DEPTH cycles.
  - In stream cycle k, A_OUT=A[k] and B_OUT=B[k].
  - k increments each cycle. After k=DEPTH-1, next state is WAIT and the wait counter is cleared.
  - Outside STREAM, A_OUT and B_OUT are 0.
- WAIT:
  - If DONE_IN=1, capture RESULT_IN into DOT_RESULT, set RESULT_VALID and go to IDLE.
  - Otherwise increment the wait counter. If it reaches TIMEOUT, set ERR, leave DOT_RESULT unchanged and go to IDLE.
- Timing:
  - GO high in cycle c0 gives START_OUT in c1 and elements 0..7 in c2..c9.
  - The compute block raises DONE in c10.
  - RESULT_VALID is high from c11.
- DONE_IN is ignored in every state except WAIT, so a stale done level from a previous run has no effect.
- Width: operands and result pass through unchanged. Overflow and truncation belong to the compute block.
- GO while BUSY=1 is ignored and is not queued.
- RST asserted at any point, including mid-STREAM, aborts the run immediately and applies the full reset behaviour including holdoff.

Decomposition:
- Shared package contents:
  - State encoding: IDLE, KICK, STREAM, WAIT.
  - The DEPTH, WIDTH and RES_W constants, shared with the compute block so that the iteration count cannot diverge.
- One natural sub-module: operand_bank. It is a DEPTH x WIDTH register file with a synchronous write port, an asynchronous read port and synchronous clear. It is instantiated twice, once for A and once for B.

Test Plan:
- Load A=1..8 and all B=1, pulse GO, run against the compute model -> START_OUT high in c1 only; A_OUT values 1..8 in c2..c9; DOT_RESULT=0x0024 with RESULT_VALID high in c11.
- Load A=B=0xFF in all entries and run -> DOT_RESULT=0xF008 (truncated 520200); ERR=0.
- Hold DONE_IN=0 through WAIT -> ERR=1 after 4 WAIT cycles; RESULT_VALID=0; DOT_RESULT keeps its prior value; the next GO clears ERR.
- Write A[3]=0x55 while BUSY=1, then re-run with B=one-hot at index 3 -> result is the old A[3], proving the write was dropped. GO pulsed mid-run -> no second START_OUT.
- Assert RST in stream cycle 4 -> all outputs 0 on the next cycle; GO during the next 9 cycles is ignored with BUSY=1; GO on cycle 10 is accepted.
- Pulse GO together with WE writing B[0]=0x02, with A[0]=0x03 and all other entries 0 -> DOT_RESULT=0x0006.
